// File: rtl/spi_regbank_if.sv
// Bus bundle between an upstream SPI slave (byte level) and spi_regbank.
// The slave modport is the register bank's view; the master modport is the
// view of whatever drives the SPI byte stream and observes the registers.
interface spi_regbank_if;
  logic       spi_cs_i;
  logic [7:0] rx_byte_i;
  logic       new_octet_i;
  logic [7:0] status_i;
  logic [7:0] tx_byte_o;
  logic [7:0] reg0_o;
  logic [7:0] reg1_o;
  logic [7:0] reg2_o;
  logic [7:0] reg3_o;
  logic       wr_o;
  logic [1:0] wr_addr_o;

  modport slave (
    input  spi_cs_i, rx_byte_i, new_octet_i, status_i,
    output tx_byte_o, reg0_o, reg1_o, reg2_o, reg3_o, wr_o, wr_addr_o
  );

  modport master (
    output spi_cs_i, rx_byte_i, new_octet_i, status_i,
    input  tx_byte_o, reg0_o, reg1_o, reg2_o, reg3_o, wr_o, wr_addr_o
  );
endinterface

// File: rtl/spi_regbank.sv
// SPI-fed control register bank: 4 RW registers, status and version readback.
// Optional feature macro: SPI_REGBANK_READBACK_EN (drives tx_byte_o in READ).
//
// state | meaning
// IDLE  | CS high, or waiting for a genuine CS falling edge
// CMD   | frame open, next octet is the command byte
// WRITE | each octet writes reg[addr] (addr 0-3), addr auto-increments
// READ  | tx_byte_o presents data at addr, addr auto-increments per octet
module spi_regbank #(
  parameter logic [7:0] VERSION = 8'hA5
) (
  input logic          clk_i,
  input logic          rst_n_i,
  spi_regbank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t     state_q, state_d;
  logic       cs_s1_q, cs_s2_q, cs_prev_q;
  logic [1:0] fill_q;
  logic       oct_s1_q, oct_s2_q, oct_prev_q;
  logic [2:0] addr_q, addr_d;
  logic [7:0] reg_q [4];
  logic [7:0] tx_q, tx_d;
  logic       wr_q, wr_d;
  logic [1:0] wr_addr_q;
  logic       oct_evt, cs_fall;

  assign oct_evt = oct_s2_q & ~oct_prev_q;
  // cs_prev_q only becomes 1 from a real synchronized sample, so the reset
  // value of the synchronizer can never fake a falling edge after reset.
  assign cs_fall = ~cs_s2_q & cs_prev_q;

  // Synchronizers and edge-detect history.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_prev_q  <= 1'b0;
      fill_q     <= 2'b00;
      oct_s1_q   <= 1'b0;
      oct_s2_q   <= 1'b0;
      oct_prev_q <= 1'b0;
    end else begin
      cs_s1_q    <= bus.spi_cs_i;
      cs_s2_q    <= cs_s1_q;
      fill_q     <= {fill_q[0], 1'b1};
      cs_prev_q  <= cs_s2_q & fill_q[1];
      oct_s1_q   <= bus.new_octet_i;
      oct_s2_q   <= oct_s1_q;
      oct_prev_q <= oct_s2_q;
    end
  end

  // Next state, address sequencing and write strobe; CS high always wins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    if (cs_s2_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) state_d = CMD;
        CMD: if (oct_evt) begin
          addr_d  = bus.rx_byte_i[2:0];
          state_d = bus.rx_byte_i[7] ? READ : WRITE;
        end
        WRITE: if (oct_evt) begin
          wr_d   = ~addr_q[2];
          addr_d = addr_q + 3'd1;
        end
        READ: if (oct_evt) addr_d = addr_q + 3'd1;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SPI_REGBANK_READBACK_EN
  // Read data follows the upcoming address so it is ready one clock later.
  always_comb begin
    tx_d = 8'h00;
    if (state_d == READ) begin
      case (addr_d)
        3'd0: tx_d = reg_q[0];
        3'd1: tx_d = reg_q[1];
        3'd2: tx_d = reg_q[2];
        3'd3: tx_d = reg_q[3];
        3'd4: tx_d = bus.status_i;
        3'd5: tx_d = VERSION;
        default: tx_d = 8'h00;
      endcase
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^{bus.status_i, VERSION};

  // Without readback the shift-out byte is held at zero.
  always_comb begin
    tx_d = 8'h00;
  end
`endif

  // State, address, register file and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= 3'd0;
      reg_q[0]  <= 8'h00;
      reg_q[1]  <= 8'h80;
      reg_q[2]  <= 8'h80;
      reg_q[3]  <= 8'h00;
      tx_q      <= 8'h00;
      wr_q      <= 1'b0;
      wr_addr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      if (wr_d) begin
        reg_q[addr_q[1:0]] <= bus.rx_byte_i;
        wr_addr_q          <= addr_q[1:0];
      end
    end
  end

  assign bus.tx_byte_o = tx_q;
  assign bus.reg0_o    = reg_q[0];
  assign bus.reg1_o    = reg_q[1];
  assign bus.reg2_o    = reg_q[2];
  assign bus.reg3_o    = reg_q[3];
  assign bus.wr_o      = wr_q;
  assign bus.wr_addr_o = wr_addr_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Scoreboard bench for spi_regbank: expected register writes are queued by
// the stimulus and popped by a monitor on every wr_o pulse.
module tb_spi_regbank;

  logic clk;
  logic rst_n;

  spi_regbank_if bus ();

  spi_regbank dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] v);
`ifdef SPI_REGBANK_READBACK_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  function automatic logic [7:0] reg_at(input logic [1:0] a);
    case (a)
      2'd0: return bus.reg0_o;
      2'd1: return bus.reg1_o;
      2'd2: return bus.reg2_o;
      default: return bus.reg3_o;
    endcase
  endfunction

  // Monitor: each wr_o pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n && bus.wr_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: wr_o pulse addr %0d data %02h, none expected",
                 bus.wr_addr_o, reg_at(bus.wr_addr_o));
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", {6'd0, bus.wr_addr_o}, {6'd0, e.a});
        check("wr_data", reg_at(bus.wr_addr_o), e.d);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_begin();
    bus.spi_cs_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic cs_end();
    bus.spi_cs_i = 1'b1;
    wait_clks(4);
  endtask

  task automatic send_octet(input logic [7:0] b);
    bus.rx_byte_i   = b;
    bus.new_octet_i = 1'b0;
    wait_clks(4);
    bus.new_octet_i = 1'b1;
    wait_clks(4);
    bus.new_octet_i = 1'b0;
  endtask

  task automatic send_octet_cs_rise(input logic [7:0] b);
    bus.rx_byte_i   = b;
    bus.new_octet_i = 1'b0;
    wait_clks(4);
    bus.spi_cs_i    = 1'b1;
    bus.new_octet_i = 1'b1;
    wait_clks(4);
    bus.new_octet_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
    check({tag, "_reg0"}, bus.reg0_o, r0);
    check({tag, "_reg1"}, bus.reg1_o, r1);
    check({tag, "_reg2"}, bus.reg2_o, r2);
    check({tag, "_reg3"}, bus.reg3_o, r3);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.spi_cs_i    = 1'b1;
    bus.new_octet_i = 1'b0;
    bus.rx_byte_i   = 8'h00;
    bus.status_i    = 8'h5A;
    wait_clks(3);
    check("rst_active_reg1", bus.reg1_o, 8'h80);
    check("rst_active_wr", {7'd0, bus.wr_o}, 8'h00);
    rst_n = 1'b1;
    wait_clks(6);

    check_regs("reset", 8'h00, 8'h80, 8'h80, 8'h00);
    check("reset_tx", bus.tx_byte_o, 8'h00);

    // Write reg1, reg2 with auto-increment.
    cs_begin();
    send_octet(8'h01);
    exp_q.push_back('{a: 2'd1, d: 8'h3C});
    send_octet(8'h3C);
    check("write_tx", bus.tx_byte_o, 8'h00);
    exp_q.push_back('{a: 2'd2, d: 8'h44});
    send_octet(8'h44);
    cs_end();
    check_regs("wr12", 8'h00, 8'h3C, 8'h44, 8'h00);

    // Write reg3, then addr 4 must be dropped.
    cs_begin();
    send_octet(8'h03);
    exp_q.push_back('{a: 2'd3, d: 8'h11});
    send_octet(8'h11);
    send_octet(8'h22);
    cs_end();
    check_regs("wr3", 8'h00, 8'h3C, 8'h44, 8'h11);

    // Read status, version, then unmapped addr 6.
    cs_begin();
    send_octet(8'h84);
    check("rd_status", bus.tx_byte_o, exp_rd(8'h5A));
    send_octet(8'hFF);
    check("rd_version", bus.tx_byte_o, exp_rd(8'hA5));
    send_octet(8'hFF);
    check("rd_addr6", bus.tx_byte_o, 8'h00);
    cs_end();
    check("idle_tx", bus.tx_byte_o, 8'h00);

    // Read registers 1..3 then status after wrapping into addr 4.
    bus.status_i = 8'hC3;
    cs_begin();
    send_octet(8'h81);
    check("rd_reg1", bus.tx_byte_o, exp_rd(8'h3C));
    send_octet(8'h00);
    check("rd_reg2", bus.tx_byte_o, exp_rd(8'h44));
    send_octet(8'h00);
    check("rd_reg3", bus.tx_byte_o, exp_rd(8'h11));
    send_octet(8'h00);
    check("rd_status2", bus.tx_byte_o, exp_rd(8'hC3));
    cs_end();

    // Command-only frame changes nothing.
    cs_begin();
    send_octet(8'h02);
    cs_end();
    check_regs("cmdonly", 8'h00, 8'h3C, 8'h44, 8'h11);

    // CS rises with the data octet: octet discarded, FSM back in IDLE.
    cs_begin();
    send_octet(8'h00);
    send_octet_cs_rise(8'h77);
    check("collide_reg0", bus.reg0_o, 8'h00);
    check("collide_state", {6'd0, dut.state_q}, 8'h00);

    // Reset in the middle of a write frame with CS held low.
    cs_begin();
    send_octet(8'h00);
    exp_q.push_back('{a: 2'd0, d: 8'h99});
    send_octet(8'h99);
    wait_clks(2);
    check("pre_rst_reg0", bus.reg0_o, 8'h99);
    rst_n = 1'b0;
    wait_clks(2);
    check_regs("midrst", 8'h00, 8'h80, 8'h80, 8'h00);
    rst_n = 1'b1;
    wait_clks(2);
    send_octet(8'h12);
    send_octet(8'h34);
    wait_clks(2);
    check_regs("cutframe", 8'h00, 8'h80, 8'h80, 8'h00);
    cs_end();

    // Next frame after a proper CS edge works again.
    cs_begin();
    send_octet(8'h02);
    exp_q.push_back('{a: 2'd2, d: 8'h66});
    send_octet(8'h66);
    cs_end();
    check_regs("after_rst", 8'h00, 8'h80, 8'h66, 8'h00);

    wait_clks(4);
    check("pending_writes", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 Parameter VERSION, default 8'hA5, constant returned at address 5.
REQ-002 clk_i  input  1  system clock; all state on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 spi_cs_i  input  1  SPI chip select, active-low, asynchronous to clk_i.
REQ-005 rx_byte_i  input  8  last received SPI byte from the upstream SPI slave.
REQ-006 new_octet_i  input  1  byte-complete flag from the SPI slave, asynchronous to clk_i.
REQ-007 status_i  input  8  read-only status, sampled at read time.
REQ-008 tx_byte_o  output  8  byte the SPI slave shifts out next.
REQ-009 reg0_o..reg3_o  output  8 each  control registers.
REQ-010 wr_o  output  1  one-cycle pulse on each register write.
REQ-011 wr_addr_o  output  2  index of the register written, valid with wr_o.

Function
REQ-012 spi_cs_i and new_octet_i SHALL each pass through a 2-FF synchronizer; an octet event is a synchronized 0->1 edge of new_octet_i.
REQ-013 rx_byte_i SHALL be captured on the octet-event cycle; clk_i SHALL be at least 4x SCK frequency.
REQ-014 FSM states: IDLE, CMD, WRITE, READ, with reset state IDLE.
REQ-015 IDLE->CMD when synchronized CS is low and was high on the previous cycle (falling edge only).
REQ-016 In CMD, an octet event SHALL decode the byte: bit7=1 means READ, bit7=0 means WRITE; addr=bits[2:0]; bits[6:3] ignored.
REQ-017 Any state SHALL return to IDLE when synchronized CS is high; CS-high in the same cycle as an octet event takes priority and the octet is discarded.
REQ-018 In WRITE, each octet event with addr 0-3 SHALL load reg[addr] and pulse wr_o with wr_addr_o=addr one cycle later; addr 4-7 writes are ignored with no wr_o pulse.
REQ-019 In READ, tx_byte_o SHALL map addr 0-3 to reg0-3, 4 to status_i, 5 to VERSION, and 6-7 to 8'h00.
REQ-020 tx_byte_o SHALL be valid within 3 clk_i cycles after the command octet event and after each READ octet event.
REQ-021 addr SHALL increment after every data octet in WRITE and READ, 3-bit wrap 7->0.
REQ-022 tx_byte_o SHALL be 8'h00 in IDLE, CMD and WRITE.
REQ-023 Frames of any length are legal; a frame holding only a command byte changes no register.

Reset
REQ-024 While rst_n_i is low: reg0_o=8'h00, reg1_o=8'h80, reg2_o=8'h80, reg3_o=8'h00, tx_byte_o=8'h00, wr_o=0, wr_addr_o=0, addr=0, FSM=IDLE, synchronizers=1 for CS and 0 for octet.
REQ-025 After release with CS already low, the FSM SHALL stay in IDLE until CS is seen high and then low, so a frame cut by reset is ignored.

Configuration
REQ-026 Macro SPI_REGBANK_READBACK_EN: when defined, READ behaves per REQ-019/020.
REQ-027 When it is undefined, read commands still enter READ and advance addr, but tx_byte_o stays 8'h00 and status_i is unused.

Verification
REQ-028 Reset release, no traffic -> reg0..3 = 00/80/80/00, tx_byte_o=00, wr_o never pulses.
REQ-029 Frame 0x01,0x3C,0x44 -> reg1=3C, reg2=44, two wr_o pulses with wr_addr_o=1 then 2.
REQ-030 Frame 0x03,0x11,0x22 -> reg3=11, then addr wraps past 4-7; 0x22 lands at addr 4 and is ignored; one wr_o pulse only.
REQ-031 With READBACK_EN and status_i=5A, frame 0x84,xx,xx -> tx_byte_o=5A, then A5, within 3 clocks of each octet; without READBACK_EN -> 00, 00.
REQ-032 CS raised on the same cycle as the octet event of data byte 0x77 in a write to addr 0 -> reg0 unchanged, FSM=IDLE.
REQ-033 rst_n_i pulsed low mid-write frame, CS still low -> registers at reset values; later octets in that frame are ignored until the next CS falling edge.
